// File: rtl/prio_encoder_n.sv
// One-entry registered priority encoder with valid/ready handshake and a multi-hot error counter.
// Define ROUND_ROBIN_EN to replace fixed LSB-first priority with a rotating-pointer scheme.
module prio_encoder_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] y,
  output logic             none,
  output logic             multi,
  output logic [7:0]       err_cnt
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] y_q, y_d;
  logic             none_q, none_d;
  logic             multi_q, multi_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             accept;
  logic [IDX_W-1:0] win;
  logic             vec_none;
  logic             vec_multi;

  assign vec_none  = ~|i;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign vec_multi = |(i & (i - WIDTH'(1)));

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   rot;
  logic [IDX_W:0]     off;
  logic [IDX_W:0]     sum;
  logic               found;

  // Rotate so bit ptr lands at position 0, then take the lowest set bit.
  always_comb begin
    dbl   = {i, i} >> ptr_q;
    rot   = dbl[WIDTH-1:0];
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!found && rot[k]) begin
        off   = (IDX_W+1)'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr_q} + off;
    if (sum >= (IDX_W+1)'(WIDTH)) begin
      sum = sum - (IDX_W+1)'(WIDTH);
    end
    win = found ? sum[IDX_W-1:0] : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && !vec_none) begin
      ptr_d = (win == IDX_W'(WIDTH - 1)) ? '0 : win + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!found && i[k]) begin
        win   = IDX_W'(k);
        found = 1'b1;
      end
    end
  end
`endif

  assign out_valid = (state_q == StFull);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    none_d    = none_q;
    multi_d   = multi_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      state_d = StFull;
      y_d     = win;
      none_d  = vec_none;
      multi_d = vec_multi;
      if (vec_multi && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      y_q       <= '0;
      none_q    <= 1'b0;
      multi_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      none_q    <= none_d;
      multi_q   <= multi_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign y       = y_q;
  assign none    = none_q;
  assign multi   = multi_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_prio_encoder_n.sv
// Randomised and directed bench for prio_encoder_n against a behavioural model.
module tb_prio_encoder_n;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] i;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] y;
  logic       none;
  logic       multi;
  logic [7:0] err_cnt;

  int tests;
  int fails;

  prio_encoder_n #(.WIDTH(8), .IDX_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .i        (i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .none     (none),
    .multi    (multi),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the held result, the error count and the search start point.
  logic       m_valid;
  logic [2:0] m_y;
  logic       m_none;
  logic       m_multi;
  int         m_err;
  int         m_ptr;

  function automatic int winner(input logic [7:0] v, input int start);
    for (int k = 0; k < 8; k++) begin
      if (v[(start + k) % 8]) return (start + k) % 8;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_y     <= '0;
      m_none  <= 1'b0;
      m_multi <= 1'b0;
      m_err   <= 0;
      m_ptr   <= 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_y     <= 3'(winner(i, m_ptr));
      m_none  <= (i == 8'h00);
      m_multi <= ($countones(i) >= 2);
      if ($countones(i) >= 2 && m_err < 255) m_err <= m_err + 1;
`ifdef ROUND_ROBIN_EN
      if (i != 8'h00) m_ptr <= (winner(i, m_ptr) + 1) % 8;
`endif
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: every falling edge the DUT must agree with the model.
  initial begin
    forever begin
      @(negedge clk);
      check("in_ready", int'(in_ready), int'(!m_valid || out_ready || !rst_n));
      check("out_valid", int'(out_valid), int'(m_valid));
      check("err_cnt", int'(err_cnt), m_err);
      if (m_valid || !rst_n) begin
        check("y", int'(y), int'(m_y));
        check("none", int'(none), int'(m_none));
        check("multi", int'(multi), int'(m_multi));
      end
    end
  end

  // Present v until accepted; returns #1 after the accepting edge with in_valid dropped.
  task automatic push(input logic [7:0] v);
    int n;
    in_valid = 1'b1;
    i        = v;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 50) check("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [2:0] held_y;

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    i         = '0;
    #2;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_err_cnt", int'(err_cnt), 0);
    check("reset_y", int'(y), 0);
    check("reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // One-hot sweep.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push(8'(1 << k));
      check("onehot_valid", int'(out_valid), 1);
      check("onehot_y", int'(y), k);
      check("onehot_multi", int'(multi), 0);
      check("onehot_none", int'(none), 0);
    end

    push(8'b0001_0010);
    check("multi_y", int'(y), 1);
    check("multi_flag", int'(multi), 1);
    check("multi_err", int'(err_cnt), 1);
    push(8'h00);
    check("zero_y", int'(y), 0);
    check("zero_none", int'(none), 1);
    check("zero_multi", int'(multi), 0);
    check("zero_err", int'(err_cnt), 1);

    // Stall: consumer blocks for five cycles while a new word waits.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push(8'b0000_1000);
    held_y   = y;
    in_valid = 1'b1;
    i        = 8'b0100_0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_y", int'(y), 3);
      check("stall_hold", int'(y), int'(held_y));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("nobubble_valid", int'(out_valid), 1);
    check("nobubble_y", int'(y), 6);

    // Saturation.
    in_valid = 1'b1;
    i        = 8'hFF;
    repeat (300) @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("sat_err", int'(err_cnt), 255);
    @(posedge clk);
    #1;
    check("sat_hold", int'(err_cnt), 255);
    check("sat_full", int'(out_valid), 1);

    // Asynchronous reset while full.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", int'(out_valid), 0);
    check("async_err", int'(err_cnt), 0);
    check("async_y", int'(y), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_reset_valid", int'(out_valid), 0);

    // Pointer behaviour on a two-bit vector.
    out_ready = 1'b1;
    push(8'h81);
    check("rr1_y", int'(y), 0);
    push(8'h81);
`ifdef ROUND_ROBIN_EN
    check("rr2_y", int'(y), 7);
`else
    check("rr2_y", int'(y), 0);
`endif
    push(8'h81);
    check("rr3_y", int'(y), 0);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       i = 8'h00;
        1:       i = 8'(1 << $urandom_range(0, 7));
        default: i = 8'($urandom);
      endcase
      if (c == 1500) begin
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prio_encoder_n.md
PRIO_ENCODER_N -- requirements
Module: prio_encoder_n

Interface
REQ-001 Parameter WIDTH, default 8, is the number of request bits (legal range 2..256).
REQ-002 Parameter IDX_W, default 3, is the index width and SHALL equal ceil(log2(WIDTH)).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  an input word is presented on i.
REQ-006 in_ready  output  1  block accepts i this cycle.
REQ-007 i  input  WIDTH  request vector to encode.
REQ-008 out_valid  output  1  y, none and multi hold a result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 y  output  IDX_W  index of the winning set bit.
REQ-011 none  output  1  accepted vector was all zeros.
REQ-012 multi  output  1  accepted vector had more than one bit set.
REQ-013 err_cnt  output  8  saturating count of accepted multi-hot vectors.

Function
REQ-014 The block SHALL be a one-entry registered stage with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-016 Accept SHALL occur when in_valid && in_ready; the result appears with out_valid=1 on the next cycle (latency 1).
REQ-017 Transitions: EMPTY->FULL on accept; FULL->FULL on accept with out_ready=1; FULL->EMPTY on out_ready=1 without accept; otherwise hold.
REQ-018 While FULL and out_ready=0, y, none and multi SHALL hold stable and no input is accepted.
REQ-019 Fixed-priority mode: y SHALL be the index of the lowest-numbered set bit of i.
REQ-020 For i == 0, y SHALL be 0, none=1, multi=0.
REQ-021 multi SHALL be 1 when the population count of i is >= 2, else 0.
REQ-022 err_cnt SHALL increment by 1 on each accept with multi-hot i, and saturate at 255.
REQ-023 Simultaneous accept and drain in FULL SHALL replace the result with no bubble cycle.
REQ-024 Inputs on i when in_valid=0 or in_ready=0 SHALL have no effect on any state.

Reset
REQ-025 Asserting rst_n low SHALL immediately force out_valid=0, y=0, none=0, multi=0, err_cnt=0 and state EMPTY.
REQ-026 Reset mid-operation SHALL discard any held result; no stale result appears after release.
REQ-027 After rst_n rises, the first accept is possible on the first clock edge with in_valid=1.

Configuration
REQ-028 Macro ROUND_ROBIN_EN SHALL select the priority scheme at compile time.
REQ-029 Without ROUND_ROBIN_EN, fixed LSB-first priority per REQ-019 applies and no pointer register exists.
REQ-030 With ROUND_ROBIN_EN, an IDX_W-bit pointer ptr (reset 0) SHALL exist; the winner is the first set bit at or above ptr, wrapping from WIDTH-1 to 0.
REQ-031 With ROUND_ROBIN_EN, each accept of non-zero i SHALL set ptr to (y+1) mod WIDTH; zero vectors leave ptr unchanged.
REQ-032 All other behaviour (handshake, none, multi, err_cnt, reset) SHALL be identical in both builds.

Verification (WIDTH=8, IDX_W=3)
REQ-033 Sweep one-hot i=8'b00000001..8'b10000000, out_ready=1 -> y=0..7 each one cycle after accept, multi=0, none=0.
REQ-034 i=8'b00010010 -> y=1, multi=1, err_cnt=1; i=8'b00000000 -> y=0, none=1, err_cnt unchanged.
REQ-035 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable; raise out_ready -> next word accepted in the same cycle, no bubble.
REQ-036 300 consecutive accepts of i=8'hFF -> err_cnt reaches 255 and stays 255.
REQ-037 Drop rst_n asynchronously while FULL -> out_valid and err_cnt are 0 before the next clock edge.
REQ-038 ROUND_ROBIN_EN built: i=8'h81 accepted three times -> y=0, 7, 0; without the macro -> y=0, 0, 0.
